// File: rtl/fft_sdf_sched.sv
// fft_sdf_sched
//   Central sequencer for a 32-point, 5-stage radix-2 SDF FFT pipeline.
//   It counts input samples, tracks every frame in flight by its age (cycles
//   since its first sample), and decodes per-stage butterfly selects, twiddle
//   enables/indices and the output framing from that registered state.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   valid_i  in   input sample strobe (a frame is 32 consecutive high cycles)
//   sel      out  [4:0] per-stage butterfly (1) / fill (0) select
//   tw_en    out  [3:0] per-stage twiddle multiply enable, stages 0..3
//   tw_idx0..tw_idx3 out [3:0] twiddle exponent k of W32^k, 0 when disabled
//   valid_o  out  FFT output sample valid
//   sop_o    out  first output sample of a frame
//   eop_o    out  last output sample of a frame
//   busy     out  a frame is accepted but not yet fully output
//   err      out  one-cycle pulse after a frame abort
module fft_sdf_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    output logic [4:0] sel,
    output logic [3:0] tw_en,
    output logic [3:0] tw_idx0,
    output logic [3:0] tw_idx1,
    output logic [3:0] tw_idx2,
    output logic [3:0] tw_idx3,
    output logic       valid_o,
    output logic       sop_o,
    output logic       eop_o,
    output logic       busy,
    output logic       err
);

    // A frame lives from age 1 to age 68 (one cycle past its last output, so
    // busy covers that cycle). Frames start at least 32 cycles apart, hence at
    // most three can be alive at once.
    localparam int         NSLOT    = 3;
    localparam logic [6:0] AGE_LAST = 7'd68;

    // Cycle offset of each stage's input window from frame start.
    function automatic logic [6:0] win_start(input int s);
        case (s)
            0:       win_start = 7'd0;
            1:       win_start = 7'd17;
            2:       win_start = 7'd26;
            3:       win_start = 7'd31;
            4:       win_start = 7'd34;
            default: win_start = 7'd36;
        endcase
    endfunction

    // (o mod L_t) keeps the low (4 - t) bits of the offset.
    function automatic logic [3:0] tw_mask(input int t);
        case (t)
            0:       tw_mask = 4'hF;
            1:       tw_mask = 4'h7;
            2:       tw_mask = 4'h3;
            default: tw_mask = 4'h1;
        endcase
    endfunction

    logic [4:0]       idx_q, idx_d;
    logic [NSLOT-1:0] act_q, act_d;
    logic [6:0]       age_q [NSLOT];
    logic [6:0]       age_d [NSLOT];
    logic             err_q, err_d;
    logic             abort;
    logic             alloc_done;
    logic [3:0]       twi [4];

    // Sample missing in the middle of a frame.
    assign abort = (idx_q != 5'd0) && !valid_i;

    always_comb begin
        idx_d      = idx_q;
        act_d      = act_q;
        err_d      = 1'b0;
        alloc_done = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
            age_d[k] = age_q[k];
            if (act_q[k]) begin
                if (age_q[k] == AGE_LAST) begin
                    act_d[k] = 1'b0;
                    age_d[k] = 7'd0;
                end else begin
                    age_d[k] = age_q[k] + 7'd1;
                end
            end
        end
        if (abort) begin
            // Flush everything, including complete frames still draining.
            idx_d = 5'd0;
            act_d = '0;
            err_d = 1'b1;
            for (int k = 0; k < NSLOT; k++) begin
                age_d[k] = 7'd0;
            end
        end else if (valid_i) begin
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'd0) begin
                // Slot freed this cycle may be reused immediately.
                for (int k = 0; k < NSLOT; k++) begin
                    if (!alloc_done && !act_d[k]) begin
                        act_d[k]   = 1'b1;
                        age_d[k]   = 7'd1;
                        alloc_done = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 5'd0;
            act_q <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < NSLOT; k++) begin
                age_q[k] <= 7'd0;
            end
        end else begin
            idx_q <= idx_d;
            act_q <= act_d;
            err_q <= err_d;
            for (int k = 0; k < NSLOT; k++) begin
                age_q[k] <= age_d[k];
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        logic [6:0] lo;
        logic [6:0] off;
        logic [4:0] j;
        logic [3:0] m;
        lo      = 7'd0;
        off     = 7'd0;
        j       = 5'd0;
        m       = 4'd0;
        sel     = '0;
        tw_en   = '0;
        valid_o = 1'b0;
        sop_o   = 1'b0;
        eop_o   = 1'b0;
        for (int t = 0; t < 4; t++) begin
            twi[t] = 4'd0;
        end
        // Stage 0 local index is the input sample index itself.
        sel[0] = idx_q[4];
        // Stage s window also carries the twiddle of stage s-1.
        for (int s = 1; s <= 4; s++) begin
            for (int k = 0; k < NSLOT; k++) begin
                lo  = win_start(s);
                off = age_q[k] - lo;
                if (act_q[k] && (age_q[k] >= lo) && (off <= 7'd31)) begin
                    j            = off[4:0];
                    sel[s]       = j[4-s];
                    tw_en[s-1]   = j[5-s];
                    if (j[5-s]) begin
                        m        = j[3:0] & tw_mask(s - 1);
                        twi[s-1] = m << (s - 1);
                    end
                end
            end
        end
        // Stage 5 window is the pipeline output.
        for (int k = 0; k < NSLOT; k++) begin
            lo  = win_start(5);
            off = age_q[k] - lo;
            if (act_q[k] && (age_q[k] >= lo) && (off <= 7'd31)) begin
                valid_o = 1'b1;
                sop_o   = (off == 7'd0);
                eop_o   = (off == 7'd31);
            end
        end
    end

    assign tw_idx0 = twi[0];
    assign tw_idx1 = twi[1];
    assign tw_idx2 = twi[2];
    assign tw_idx3 = twi[3];
    assign busy    = |act_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fft_sdf_sched.sv
module tb_fft_sdf_sched;

    logic       clk;
    logic       rst;
    logic       valid_i;
    logic [4:0] sel;
    logic [3:0] tw_en;
    logic [3:0] tw_idx0, tw_idx1, tw_idx2, tw_idx3;
    logic       valid_o, sop_o, eop_o, busy, err;

    fft_sdf_sched dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .sel     (sel),
        .tw_en   (tw_en),
        .tw_idx0 (tw_idx0),
        .tw_idx1 (tw_idx1),
        .tw_idx2 (tw_idx2),
        .tw_idx3 (tw_idx3),
        .valid_o (valid_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic sop;
        logic eop;
    } rec_t;

    int   D [6] = '{0, 17, 26, 31, 34, 36};
    int   n;          // cycle number since reset release
    int   mi;         // model input index
    logic err_exp;
    int   starts [$]; // frame start cycles still in flight
    rec_t sb [$];     // expected output samples of complete frames
    int   cmp;
    int   mism;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_cycle();
        int e_sel, e_twen, e_vo, e_sop, e_eop, e_busy;
        int e_idx [4];
        int a, j, o, en;
        rec_t r;
        while (starts.size() > 0 && (n - starts[0]) > 68) void'(starts.pop_front());
        e_sel = 0; e_twen = 0; e_vo = 0; e_sop = 0; e_eop = 0; e_busy = 0;
        for (int t = 0; t < 4; t++) e_idx[t] = 0;
        foreach (starts[f]) begin
            a = n - starts[f];
            for (int s = 0; s <= 4; s++) begin
                if (a >= D[s] && a <= D[s] + 31) begin
                    j = a - D[s];
                    e_sel |= ((j >> (4 - s)) & 1) << s;
                end
            end
            for (int t = 0; t < 4; t++) begin
                if (a >= D[t+1] && a <= D[t+1] + 31) begin
                    o  = a - D[t+1];
                    en = (o >> (4 - t)) & 1;
                    e_twen |= en << t;
                    if (en != 0) e_idx[t] = (o % (16 >> t)) << t;
                end
            end
            if (a >= D[5] && a <= D[5] + 31) begin
                o     = a - D[5];
                e_vo  = 1;
                e_sop = (o == 0) ? 1 : 0;
                e_eop = (o == 31) ? 1 : 0;
            end
            if (a >= 1 && a <= 68) e_busy = 1;
        end
        chk("sel",     32'(sel),     32'(e_sel));
        chk("tw_en",   32'(tw_en),   32'(e_twen));
        chk("tw_idx0", 32'(tw_idx0), 32'(e_idx[0]));
        chk("tw_idx1", 32'(tw_idx1), 32'(e_idx[1]));
        chk("tw_idx2", 32'(tw_idx2), 32'(e_idx[2]));
        chk("tw_idx3", 32'(tw_idx3), 32'(e_idx[3]));
        chk("valid_o", 32'(valid_o), 32'(e_vo));
        chk("sop_o",   32'(sop_o),   32'(e_sop));
        chk("eop_o",   32'(eop_o),   32'(e_eop));
        chk("busy",    32'(busy),    32'(e_busy));
        chk("err",     32'(err),     32'(err_exp));
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_extra_valid", 32'(valid_o), 32'd0);
            end else begin
                r = sb.pop_front();
                chk("sb_cycle", 32'(n), 32'(r.cyc));
                chk("sb_sop", 32'(sop_o), 32'(r.sop));
                chk("sb_eop", 32'(eop_o), 32'(r.eop));
            end
        end
    endtask

    task automatic model_step(input logic v);
        rec_t r;
        if (mi != 0 && !v) begin
            starts.delete();
            sb.delete();
            mi      = 0;
            err_exp = 1'b1;
        end else begin
            err_exp = 1'b0;
            if (v) begin
                if (mi == 0) starts.push_back(n);
                if (mi == 31) begin
                    for (int k = 0; k < 32; k++) begin
                        r.cyc = starts[$] + 36 + k;
                        r.sop = (k == 0);
                        r.eop = (k == 31);
                        sb.push_back(r);
                    end
                end
                mi = (mi + 1) % 32;
            end
        end
    endtask

    task automatic tick(input logic v);
        check_cycle();
        valid_i = v;
        model_step(v);
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run(input logic v, input int cnt);
        for (int c = 0; c < cnt; c++) tick(v);
    endtask

    task automatic async_reset();
        #2;
        rst     = 1'b0;
        valid_i = 1'b0;
        starts.delete();
        sb.delete();
        mi      = 0;
        err_exp = 1'b0;
        #1;
        check_cycle();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            n++;
            check_cycle();
        end
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n++;
    endtask

    initial begin
        cmp     = 0;
        mism    = 0;
        n       = 0;
        mi      = 0;
        err_exp = 1'b0;
        rst     = 1'b0;
        valid_i = 1'b0;
        #1;
        check_cycle();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n = 0;

        // Single frame starting at cycle 10.
        run(1'b0, 10);
        run(1'b1, 32);
        run(1'b0, 80);

        // Back-to-back frames.
        run(1'b1, 64);
        run(1'b0, 80);

        // Abort after 20 samples, new frame in the err cycle.
        run(1'b1, 20);
        run(1'b0, 1);
        run(1'b1, 32);
        run(1'b0, 80);

        // Frame A complete, frame B aborts at its i = 5 while A drains.
        run(1'b1, 32);
        run(1'b1, 5);
        run(1'b0, 1);
        run(1'b0, 80);

        // Asynchronous reset mid-frame, then idle, then a fresh frame.
        run(1'b1, 12);
        async_reset();
        run(1'b0, 10);
        run(1'b1, 32);
        run(1'b0, 80);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
